// File: rtl/alu_pkg.sv
// Shared opcode, custom sub-op and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MUL    = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;
  localparam logic [2:0] OP_CUSTOM = 3'b111;

  localparam logic [1:0] CUS_NOT = 2'b00;
  localparam logic [1:0] CUS_SHL = 2'b01;
  localparam logic [1:0] CUS_SHR = 2'b10;
  localparam logic [1:0] CUS_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response handshake bundle between a requester and the sequential ALU.
interface alu_seq_unit_if #(parameter int unsigned WIDTH = 4);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               carry_out;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, carry_out
  );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Shared-accumulator datapath: right-shift shift-add multiplier and restoring divider.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic               step,
  input  logic [WIDTH-1:0]   init,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res_c
);

  localparam int unsigned RW = 2 * WIDTH;

  // mul: acc = {partial_hi, multiplier}; div: acc = {remainder, quotient}
  logic [RW-1:0]    acc;
  logic [RW-1:0]    acc_nxt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    addend  = acc[0] ? a : '0;
    sum     = {1'b0, acc[RW-1:WIDTH]} + {1'b0, addend};
    shifted = {acc[RW-1:WIDTH], acc[WIDTH-1]};
    trial   = shifted - {1'b0, b};
    acc_nxt = acc;
    if (!mode) begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else if (shifted >= {1'b0, b}) begin
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  assign res_c = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (start) begin
      acc <= {{WIDTH{1'b0}}, init};
    end else if (step) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith ops plus WIDTH-step multiply/divide.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_unit_if.slave  bus
);

  localparam int unsigned RW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state;
  state_e           state_nxt;
  logic             accept;
  logic             last_step;
  logic             dp_start;
  logic             dp_step;
  logic             dp_mode;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [RW-1:0]    result_q;
  logic             carry_q;
  logic [RW-1:0]    iter_res;
  logic [RW-1:0]    single_res;
  logic             single_carry;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] low;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (bus.opcode)
            OP_MUL:  state_nxt = ST_MUL;
            OP_DIV:  state_nxt = ST_DIV;
            default: state_nxt = ST_DONE;
          endcase
        end
      end
      ST_MUL, ST_DIV: if (last_step) state_nxt = ST_DONE;
      ST_DONE:        if (bus.out_ready) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads low throughout reset
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    dp_start      = 1'b0;
    dp_step       = 1'b0;
    dp_mode       = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.in_ready = rst_n;
        dp_start     = accept;
        dp_mode      = (bus.opcode == OP_DIV);
      end
      ST_MUL:  dp_step = 1'b1;
      ST_DIV: begin
        dp_step = 1'b1;
        dp_mode = 1'b1;
      end
      ST_DONE: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle ops, evaluated on the operands being captured this edge
  always_comb begin
    sum          = {1'b0, bus.A} + {1'b0, bus.B};
    low          = '0;
    single_carry = 1'b0;
    single_res   = '0;
    case (bus.opcode)
      OP_ADD: begin
        single_res   = RW'(sum);
        single_carry = sum[WIDTH];
      end
      OP_SUB: begin
        low          = bus.A - bus.B;
        single_carry = (bus.A < bus.B);
      end
      OP_AND: low = bus.A & bus.B;
      OP_OR:  low = bus.A | bus.B;
      OP_XOR: low = bus.A ^ bus.B;
      OP_CUSTOM: begin
        case (bus.B[1:0])
          CUS_NOT: low = ~bus.A;
          CUS_SHL: begin
            low          = {bus.A[WIDTH-2:0], 1'b0};
            single_carry = bus.A[WIDTH-1];
          end
          CUS_SHR: begin
            low          = {1'b0, bus.A[WIDTH-1:1]};
            single_carry = bus.A[0];
          end
          default: begin
            low          = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            single_carry = bus.A[WIDTH-1];
          end
        endcase
      end
      default: ;
    endcase
    if (bus.opcode != OP_ADD) single_res = RW'(low);
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dp_start),
    .mode  (dp_mode),
    .step  (dp_step),
    .init  (dp_mode ? bus.A : bus.B),
    .a     (a_q),
    .b     (b_q),
    .res_c (iter_res)
  );

  // Operand capture, iteration counter and the registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      op_q <= bus.opcode;
      cnt  <= '0;
      if (state_nxt == ST_DONE) begin
        result_q <= single_res;
        carry_q  <= single_carry;
      end
    end else if (dp_step) begin
      cnt <= cnt + CNT_W'(1);
      if (last_step) begin
        result_q <= iter_res;
        carry_q  <= (op_q == OP_DIV) && (b_q == '0);
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit with an arithmetic reference model and per-cycle output monitor.
module tb_alu_seq_unit;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_r;
  logic       exp_c;
  logic [7:0] got_r;
  logic       got_c;

  alu_seq_unit_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 4-bit operands
  task automatic model(input int a, input int b, input int op, output logic [7:0] r, output logic c);
    int res;
    int cy;
    res = 0;
    cy  = 0;
    case (op)
      0: begin res = a + b; cy = (res >= 16) ? 1 : 0; end
      1: begin res = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
      2: res = a * b;
      3: begin
        if (b == 0) begin res = a * 16 + 15; cy = 1; end
        else res = (a % b) * 16 + a / b;
      end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      default: begin
        case (b % 4)
          0: res = 15 - a;
          1: begin res = (a * 2) % 16; cy = a / 8; end
          2: begin res = a / 2; cy = a % 2; end
          default: begin res = (a * 2) % 16 + a / 8; cy = a / 8; end
        endcase
      end
    endcase
    r = res[7:0];
    c = cy[0];
  endtask

  // Whenever a result is presented it must match the model and the unit must be busy
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      check("mon_result", 16'(bus.result), 16'(exp_r));
      check("mon_carry", 16'(bus.carry_out), 16'(exp_c));
      check("mon_in_ready_low", 16'(bus.in_ready), 16'd0);
    end
  end

  task automatic run_op(input int a, input int b, input int op, input int hold,
                        output logic [7:0] r, output logic c);
    int t;
    int lat;
    int exp_lat;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("wait_in_ready_timeout", 16'd0, 16'd1);
    model(a, b, op, exp_r, exp_c);
    exp_lat = (op == 2 || op == 3) ? W + 1 : 1;
    bus.A        = 4'(a);
    bus.B        = 4'(b);
    bus.opcode   = 3'(op);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs while busy; the in-flight operation must ignore them
    bus.A      = 4'($urandom);
    bus.B      = 4'($urandom);
    bus.opcode = 3'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency_op%0d", op), 16'(lat), 16'(exp_lat));
    r = bus.result;
    c = bus.carry_out;
    for (int h = 0; h < hold; h++) begin
      check("hold_out_valid", 16'(bus.out_valid), 16'd1);
      check("hold_result_stable", 16'(bus.result), 16'(r));
      check("hold_carry_stable", 16'(bus.carry_out), 16'(c));
      check("hold_in_ready", 16'(bus.in_ready), 16'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("post_handshake_out_valid", 16'(bus.out_valid), 16'd0);
    check("post_handshake_in_ready", 16'(bus.in_ready), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = '0;
    exp_r         = '0;
    exp_c         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_result", 16'(bus.result), 16'd0);
    check("rst_carry", 16'(bus.carry_out), 16'd0);
    check("rst_in_ready", 16'(bus.in_ready), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

    // Hand-computed vectors
    run_op(10, 5, 0, 0, got_r, got_c);
    check("add_10_5_res", 16'(got_r), 16'h0F);
    check("add_10_5_carry", 16'(got_c), 16'd0);
    run_op(10, 5, 2, 0, got_r, got_c);
    check("mul_10_5_res", 16'(got_r), 16'h32);
    check("mul_10_5_carry", 16'(got_c), 16'd0);
    run_op(10, 5, 3, 0, got_r, got_c);
    check("div_10_5_res", 16'(got_r), 16'h02);
    run_op(12, 0, 3, 0, got_r, got_c);
    check("div_by_zero_res", 16'(got_r), 16'hCF);
    check("div_by_zero_carry", 16'(got_c), 16'd1);
    run_op(3, 10, 7, 0, got_r, got_c);
    check("custom_shr_res", 16'(got_r), 16'h01);
    check("custom_shr_carry", 16'(got_c), 16'd1);
    run_op(3, 1, 7, 0, got_r, got_c);
    check("custom_shl_res", 16'(got_r), 16'h06);
    check("custom_shl_carry", 16'(got_c), 16'd0);
    run_op(15, 1, 0, 0, got_r, got_c);
    check("add_carry_res", 16'(got_r), 16'h10);
    check("add_carry_carry", 16'(got_c), 16'd1);

    // Backpressure: three stalled cycles in DONE
    run_op(9, 6, 6, 3, got_r, got_c);
    check("xor_bp_res", 16'(got_r), 16'h0F);

    // Model-checked sweep (monitor compares every valid cycle)
    run_op(3, 5, 1, 0, got_r, got_c);
    check("sub_borrow_res", 16'(got_r), 16'h0E);
    check("sub_borrow_carry", 16'(got_c), 16'd1);
    run_op(9, 9, 1, 1, got_r, got_c);
    run_op(12, 10, 4, 0, got_r, got_c);
    run_op(12, 10, 5, 0, got_r, got_c);
    run_op(9, 4, 7, 0, got_r, got_c);
    run_op(9, 3, 7, 2, got_r, got_c);
    check("custom_rol_res", 16'(got_r), 16'h03);
    run_op(15, 15, 2, 0, got_r, got_c);
    check("mul_max_res", 16'(got_r), 16'hE1);
    run_op(15, 4, 3, 1, got_r, got_c);
    run_op(1, 15, 3, 0, got_r, got_c);
    run_op(0, 7, 2, 0, got_r, got_c);

    // Reset two cycles into a multiply
    @(negedge clk);
    bus.A        = 4'd7;
    bus.B        = 4'd6;
    bus.opcode   = 3'd2;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 16'(bus.out_valid), 16'd0);
    check("abort_result", 16'(bus.result), 16'd0);
    check("abort_in_ready", 16'(bus.in_ready), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_stale_valid", 16'(bus.out_valid), 16'd0);
      check("abort_in_ready_after", 16'(bus.in_ready), 16'd1);
    end
    run_op(7, 6, 2, 0, got_r, got_c);
    check("mul_after_abort_res", 16'(got_r), 16'h2A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
